// File: rtl/rnd_range_gen_pkg.sv
// Shared types and helpers for the bounded-range random generator.
// Holds the draw-engine state encoding, the default LFSR constants and the
// range-to-mask helper used when a request is accepted.
package rnd_range_gen_pkg;

  typedef enum logic [1:0] {
    RND_IDLE,
    RND_DRAW,
    RND_DONE
  } rnd_state_e;

  // Widest range/result the mask helper handles; OUT_W must not exceed this.
  localparam int RND_MAX_W = 32;

  // Default 16-bit polynomial and non-zero power-up state.
  localparam logic [15:0] RND_DEF_TAPS = 16'hD008;
  localparam logic [15:0] RND_DEF_SEED = 16'hACE1;

  // Smallest all-ones value (2^k-1) that is >= range_v: every bit at or below
  // the most significant set bit of range_v is set. range_v = 0 gives 0.
  function automatic logic [RND_MAX_W-1:0] range_mask(input logic [RND_MAX_W-1:0] range_v);
    logic [RND_MAX_W-1:0] m;
    m[RND_MAX_W-1] = range_v[RND_MAX_W-1];
    for (int i = RND_MAX_W - 2; i >= 0; i--) begin
      m[i] = m[i+1] | range_v[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/rnd_range_gen_if.sv
// Request/result handshake bundle of the random range generator.
// The slave side is the generator, the master side is the consumer.
interface rnd_range_gen_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 8
);

  logic             req_valid_i;
  logic             req_ready_o;
  logic [OUT_W-1:0] range_i;
  logic             rnd_valid_o;
  logic             rnd_ready_i;
  logic [OUT_W-1:0] rnd_o;
  logic [WIDTH-1:0] rnd_num_o;

  modport slave (
    input  req_valid_i,
    input  range_i,
    input  rnd_ready_i,
    output req_ready_o,
    output rnd_valid_o,
    output rnd_o,
    output rnd_num_o
  );

  modport master (
    output req_valid_i,
    output range_i,
    output rnd_ready_i,
    input  req_ready_o,
    input  rnd_valid_o,
    input  rnd_o,
    input  rnd_num_o
  );

endinterface

// File: rtl/rnd_range_gen_lfsr_core.sv
// Free-running Fibonacci LFSR with synchronous seed reload.
// Optional macro RND_LOCKUP_GUARD_EN: an all-zero state (reachable only by
// loading a zero seed) is replaced by SEED on the following edge.
module rnd_range_gen_lfsr_core #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q;

  // State update: reset, then reload, then (optionally) lockup escape, else shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else if (load_i) begin
      state_q <= seed_i;
`ifdef RND_LOCKUP_GUARD_EN
    end else if (state_q == '0) begin
      state_q <= SEED;
`endif
    end else begin
      state_q <= {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rnd_range_gen.sv
// Bounded-range random generator: LFSR source plus a req/ack draw engine that
// returns a uniform value in [0, range] by mask-and-reject sampling, folding
// the last candidate back into range after MAX_TRIES rejected attempts.
// Optional macro RND_LOCKUP_GUARD_EN enables the LFSR zero-state escape.
module rnd_range_gen
  import rnd_range_gen_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = RND_DEF_TAPS,
  parameter logic [WIDTH-1:0] SEED      = RND_DEF_SEED,
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  rnd_range_gen_if.slave   bus
);

  // Retry counter only needs to reach MAX_TRIES-1; keep at least one bit.
  localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  logic [WIDTH-1:0] lfsr_state;
  rnd_state_e       fsm_q;
  logic [TRY_W-1:0] tries_q;
  logic [OUT_W-1:0] range_q;
  logic [OUT_W-1:0] mask_q;
  logic [OUT_W-1:0] rnd_q;
  logic             req_ready_q;
  logic             rnd_valid_q;
  logic [OUT_W-1:0] cand;

  // A rejected candidate lies in (range, mask]; since mask <= 2*range+1,
  // subtracting range+1 always lands inside [0, range]. range+1 needs one
  // extra bit so range = all-ones does not wrap.
  function automatic logic [OUT_W-1:0] fold_down(input logic [OUT_W-1:0] c,
                                                 input logic [OUT_W-1:0] r);
    return OUT_W'({1'b0, c} - ({1'b0, r} + (OUT_W + 1)'(1)));
  endfunction

  rnd_range_gen_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (seed_load_i),
    .seed_i  (seed_i),
    .state_o (lfsr_state)
  );

  // Candidate for this cycle's attempt, taken from the live LFSR state.
  assign cand = lfsr_state[OUT_W-1:0] & mask_q;

  // Draw engine: accept a range, try one candidate per cycle, hold the result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q       <= RND_IDLE;
      tries_q     <= '0;
      range_q     <= '0;
      mask_q      <= '0;
      rnd_q       <= '0;
      req_ready_q <= 1'b1;
      rnd_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        RND_IDLE: begin
          if (bus.req_valid_i && req_ready_q) begin
            range_q     <= bus.range_i;
            mask_q      <= OUT_W'(range_mask(RND_MAX_W'(bus.range_i)));
            tries_q     <= '0;
            req_ready_q <= 1'b0;
            fsm_q       <= RND_DRAW;
          end
        end
        RND_DRAW: begin
          if (cand <= range_q) begin
            rnd_q       <= cand;
            rnd_valid_q <= 1'b1;
            fsm_q       <= RND_DONE;
          end else if (tries_q == LAST_TRY) begin
            rnd_q       <= fold_down(cand, range_q);
            rnd_valid_q <= 1'b1;
            fsm_q       <= RND_DONE;
          end else begin
            tries_q <= tries_q + TRY_W'(1);
          end
        end
        RND_DONE: begin
          if (bus.rnd_ready_i) begin
            rnd_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            tries_q     <= '0;
            fsm_q       <= RND_IDLE;
          end
        end
        default: begin
          fsm_q       <= RND_IDLE;
          req_ready_q <= 1'b1;
          rnd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.rnd_valid_o = rnd_valid_q;
  assign bus.rnd_o       = rnd_q;
  assign bus.rnd_num_o   = lfsr_state;

endmodule
